// File: rtl/enc_pkg.sv
// Shared types and helpers for the encoder speed meter.
// Averaging is compiled in when ENC_SPEED_AVG_EN is defined.
package enc_pkg;

   typedef enum logic {PRIME, RUN} speed_state_t;

   localparam int unsigned AVG_DEPTH = 4;
   localparam int unsigned AVG_SHIFT = 2;

   typedef struct packed {
      logic               clip;
      logic signed [63:0] val;
   } sat_delta_t;

   // Clamp a sign-extended delta into a signed range of sw bits.
   function automatic sat_delta_t sat_delta(input logic signed [63:0] d,
                                            input int unsigned sw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (sw - 1));
      if (d > hi)      return '{clip: 1'b1, val: hi};
      else if (d < lo) return '{clip: 1'b1, val: lo};
      else             return '{clip: 1'b0, val: d};
   endfunction

endpackage

// File: rtl/enc_tick_gen.sv
// Period timer: counts 0..PERIOD-1 while enabled, one-cycle tick on the last value.
module enc_tick_gen #(
   parameter int unsigned PERIOD = 100000
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic tick
);

   localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

   logic [TW-1:0] timer;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)               timer <= '0;
      else if (!en)            timer <= '0;
      else if (timer == LAST)  timer <= '0;
      else                     timer <= timer + TW'(1);
   end

   assign tick = en && (timer == LAST);

endmodule

// File: rtl/enc_speed_meter.sv
// Encoder velocity meter: samples the count every SAMPLE_PERIOD clocks and streams
// the saturated signed delta. Define ENC_SPEED_AVG_EN for a 4-sample moving average.
module enc_speed_meter
   import enc_pkg::*;
#(
   parameter int unsigned BAND_WIDTH    = 32,
   parameter int unsigned SPEED_WIDTH   = 16,
   parameter int unsigned SAMPLE_PERIOD = 100000
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          en,
   input  logic [BAND_WIDTH-1:0]         count,
   output logic signed [SPEED_WIDTH-1:0] speed,
   output logic                          speed_valid,
   input  logic                          speed_ready,
   output logic                          sat,
   output logic                          overrun
);

   localparam int unsigned SW = SPEED_WIDTH;

   logic                  tick;
   speed_state_t          state_q, state_d;
   logic [BAND_WIDTH-1:0] prev;
   logic [BAND_WIDTH-1:0] delta;
   logic signed [63:0]    delta_ext;
   sat_delta_t            sat_r;
   logic signed [SW-1:0]  cur_val;
   logic                  cur_clip;
   logic                  run_tick;
   logic                  load;
   logic signed [SW-1:0]  new_speed;
   logic                  new_sat;

   enc_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .en   (en),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= PRIME;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en)       state_d = PRIME;
      else if (tick) state_d = RUN;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     prev <= '0;
      else if (tick) prev <= count;
   end

   // Modular difference read as signed handles counter wrap for free.
   assign delta     = count - prev;
   assign delta_ext = 64'($signed(delta));
   assign sat_r     = sat_delta(delta_ext, SW);
   assign cur_val   = SW'(sat_r.val);
   assign cur_clip  = sat_r.clip;
   assign run_tick  = tick && (state_q == RUN);

`ifdef ENC_SPEED_AVG_EN
   // The current sample plus the three newest stored ones form the 4-deep window.
   localparam int unsigned HD = AVG_DEPTH - 1;
   localparam int unsigned AW = SW + AVG_SHIFT;

   logic signed [SW-1:0] hist [HD];
   logic [HD-1:0]        hist_sat;
   logic [2:0]           fill;
   logic signed [AW-1:0] sum;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < HD; i++) hist[i] <= '0;
         hist_sat <= '0;
         fill     <= '0;
      end else if (tick && state_q == PRIME) begin
         for (int i = 0; i < HD; i++) hist[i] <= '0;
         hist_sat <= '0;
         fill     <= '0;
      end else if (run_tick) begin
         hist[0]  <= cur_val;
         for (int i = 1; i < HD; i++) hist[i] <= hist[i-1];
         hist_sat <= {hist_sat[HD-2:0], cur_clip};
         if (fill != 3'(HD)) fill <= fill + 3'd1;
      end
   end

   always_comb begin
      sum = AW'(cur_val);
      for (int i = 0; i < HD; i++) sum = sum + AW'(hist[i]);
   end

   assign new_speed = SW'(sum >>> AVG_SHIFT);
   assign new_sat   = cur_clip | (|hist_sat);
   assign load      = run_tick && (fill == 3'(HD));
`else
   assign new_speed = cur_val;
   assign new_sat   = cur_clip;
   assign load      = run_tick;
`endif

   // Outputs and the handshake freeze while measurement is disabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         speed       <= '0;
         speed_valid <= 1'b0;
         sat         <= 1'b0;
         overrun     <= 1'b0;
      end else if (en) begin
         if (load) begin
            speed       <= new_speed;
            sat         <= new_sat;
            speed_valid <= 1'b1;
            if (speed_valid && !speed_ready) overrun <= 1'b1;
         end else if (speed_valid && speed_ready) begin
            speed_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_enc_speed_meter.sv
// Self-checking bench: directed windows plus random deltas, compared every cycle
// against a sample-level reference model.
module tb_enc_speed_meter;

   localparam int PER = 10;

   logic               clk;
   logic               rstn;
   logic               en;
   logic [31:0]        count;
   logic signed [15:0] speed;
   logic               speed_valid;
   logic               speed_ready;
   logic               sat;
   logic               overrun;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_speed;
   bit          m_valid, m_sat, m_ovr;
   logic [31:0] m_prev;
   bit          primed;
   int          ecnt;
   bit          ticked;
   int          hist_v[$];
   bit          hist_s[$];

   enc_speed_meter #(.BAND_WIDTH(32), .SPEED_WIDTH(16), .SAMPLE_PERIOD(PER)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .count       (count),
      .speed       (speed),
      .speed_valid (speed_valid),
      .speed_ready (speed_ready),
      .sat         (sat),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_speed = 0; m_valid = 0; m_sat = 0; m_ovr = 0;
      m_prev = '0; primed = 0; ecnt = 0;
      hist_v.delete(); hist_s.delete();
   endtask

   function automatic int floor_div4(input int s);
      return (s >= 0) ? s / 4 : -((-s + 3) / 4);
   endfunction

   // One sampling instant: returns 1 if a new output sample is produced.
   task automatic model_sample(output bit emitted);
      int dd, cs, sum;
      bit cl, so;
      emitted = 0;
      if (!primed) begin
         m_prev = count; primed = 1;
         hist_v.delete(); hist_s.delete();
      end else begin
         dd = count - m_prev;
         m_prev = count;
         cs = (dd > 32767) ? 32767 : (dd < -32768) ? -32768 : dd;
         cl = (cs != dd);
`ifdef ENC_SPEED_AVG_EN
         hist_v.push_back(cs); hist_s.push_back(cl);
         if (hist_v.size() > 4) begin void'(hist_v.pop_front()); void'(hist_s.pop_front()); end
         if (hist_v.size() == 4) begin
            sum = 0; so = 0;
            foreach (hist_v[i]) begin sum += hist_v[i]; so |= hist_s[i]; end
            if (m_valid && !speed_ready) m_ovr = 1;
            m_speed = floor_div4(sum); m_sat = so; m_valid = 1; emitted = 1;
         end
`else
         sum = 0; so = 0;
         if (m_valid && !speed_ready) m_ovr = 1;
         m_speed = cs; m_sat = cl; m_valid = 1; emitted = 1;
`endif
      end
   endtask

   task automatic check();
      int sp;
      sp = speed;
      checks++;
      assert (sp === m_speed) else begin errors++; $error("FAIL speed: got %0d expected %0d", sp, m_speed); end
      checks++;
      assert (speed_valid === m_valid) else begin errors++; $error("FAIL speed_valid: got %b expected %b", speed_valid, m_valid); end
      checks++;
      assert (sat === m_sat) else begin errors++; $error("FAIL sat: got %b expected %b", sat, m_sat); end
      checks++;
      assert (overrun === m_ovr) else begin errors++; $error("FAIL overrun: got %b expected %b", overrun, m_ovr); end
   endtask

   task automatic cyc();
      bit emitted;
      ticked = 0;
      @(posedge clk);
      if (!rstn) model_reset();
      else if (en) begin
         ecnt++;
         emitted = 0;
         if (ecnt % PER == 0) begin ticked = 1; model_sample(emitted); end
         if (!emitted && m_valid && speed_ready) m_valid = 0;
      end else begin
         ecnt = 0; primed = 0;
      end
      #1;
      check();
   endtask

   // Run until the next sample instant; count moves by d at a random cycle before it.
   // mode: 0 ready=1, 1 ready=0, 2 random, 3 ready only on the sample cycle.
   task automatic window(input int d, input int mode);
      int pos, n;
      bit done, will_tick;
      pos = $urandom_range(0, PER - 1 - (ecnt % PER));
      done = 0; n = 0;
      while (!done && n < 3 * PER) begin
         if (n == pos) count = count + 32'(d);
         will_tick = en && ((ecnt + 1) % PER == 0);
         case (mode)
            0: speed_ready = 1'b1;
            1: speed_ready = 1'b0;
            2: speed_ready = 1'($urandom_range(0, 1));
            default: speed_ready = will_tick;
         endcase
         cyc();
         done = ticked;
         n++;
      end
      checks++;
      assert (done) else begin errors++; $error("FAIL tick_timeout: got no sample in %0d cycles, expected one", n); end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      #2;
      check();
      repeat (2) cyc();
      rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; count = $urandom(); speed_ready = 1'b1;
      model_reset();
      #1;
      check();
      repeat (2) cyc();
      rstn = 1'b1;
      repeat (3) cyc();

      // steady +5 per window
      en = 1'b1;
      window(0, 0);
      repeat (4) window(5, 0);

      // wrap across 2^32 in both directions
      count = 32'hFFFF_FFFE;
      window(0, 0);
      window(5, 0);
      window(-5, 0);

      // saturation corners
      window(40000, 0);
      window(-40000, 0);
      window(32767, 0);
      window(32768, 0);
      window(-32768, 0);
      window(-32769, 0);

      // overrun with ready held low, then stays sticky
      window(3, 1);
      window(4, 1);
      window(5, 0);
      window(6, 0);

      // ready raised exactly on the sample cycle: no overrun
      do_reset();
      en = 1'b1;
      window(0, 0);
      window(2, 1);
      window(6, 3);
      window(1, 0);

      // enable dropped mid-window, then restored
      repeat (4) cyc();
      en = 1'b0;
      count = count + 32'd123;
      repeat (5) cyc();
      en = 1'b1;
      window(9, 0);
      window(7, 0);
      window(7, 0);

      // short delta sequence from prime (average case yields 2)
      do_reset();
      en = 1'b1;
      window(0, 0);
      window(4, 0);
      window(8, 0);
      window(-3, 0);
      window(1, 0);
      window(1, 0);

      // random deltas with random backpressure
      repeat (60) window($urandom_range(0, 100000) - 50000, 2);

      // reset mid-window, then re-prime
      repeat (3) cyc();
      rstn = 1'b0;
      model_reset();
      #2;
      check();
      cyc();
      rstn = 1'b1;
      window(0, 0);
      repeat (6) window($urandom_range(0, 200) - 100, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
